// File: rtl/hazard_unit_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared FSM state encoding and forwarding-select codes for the
//           hazard unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MEM_WAIT    = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_if.sv
// ============================================================================
// Module  : hazard_unit_if
// Brief   : Pipeline-side bundle seen by the hazard unit: register indices,
//           write enables, memory status in; stall/flush/forward controls out.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs1_D;
  logic [REG_ADDR_W-1:0] rs2_D;
  logic                  use_rs1_D;
  logic                  use_rs2_D;
  logic [REG_ADDR_W-1:0] rs1_E;
  logic [REG_ADDR_W-1:0] rs2_E;
  logic [REG_ADDR_W-1:0] rd_E;
  logic                  reg_we_E;
  logic                  is_load_E;
  logic                  branch_taken_E;
  logic [REG_ADDR_W-1:0] rd_M;
  logic                  reg_we_M;
  logic                  mem_req_M;
  logic                  dmem_ready;
  logic [REG_ADDR_W-1:0] rd_W;
  logic                  reg_we_W;

  logic                  stall_F;
  logic                  stall_D;
  logic                  stall_E;
  logic                  stall_M;
  logic                  flush_D;
  logic                  flush_E;
  logic                  flush_W;
  logic [1:0]            fwd_A_E;
  logic [1:0]            fwd_B_E;

  // Datapath side
  modport master (
    output rs1_D, rs2_D, use_rs1_D, use_rs2_D, rs1_E, rs2_E, rd_E,
           reg_we_E, is_load_E, branch_taken_E, rd_M, reg_we_M,
           mem_req_M, dmem_ready, rd_W, reg_we_W,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwd_A_E, fwd_B_E
  );

  // Hazard unit side
  modport slave (
    input  rs1_D, rs2_D, use_rs1_D, use_rs2_D, rs1_E, rs2_E, rd_E,
           reg_we_E, is_load_E, branch_taken_E, rd_M, reg_we_M,
           mem_req_M, dmem_ready, rd_W, reg_we_W,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwd_A_E, fwd_B_E
  );

endinterface

`default_nettype wire

// File: rtl/hazard_unit_fwd_sel.sv
// ============================================================================
// Module  : hazard_fwd_sel
// Brief   : Operand source select for one E-stage operand; M beats W, x0
//           never forwards.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  wire logic [REG_ADDR_W-1:0] i_rs,
  input  wire logic [REG_ADDR_W-1:0] i_rd_M,
  input  wire logic                  i_we_M,
  input  wire logic [REG_ADDR_W-1:0] i_rd_W,
  input  wire logic                  i_we_W,
  output logic      [1:0]            o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rs != '0) begin
      if (i_we_M && (i_rd_M == i_rs))
        o_sel = FWD_M;
      else if (i_we_W && (i_rd_W == i_rs))
        o_sel = FWD_W;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module  : hazard_unit
// Brief   : Stall/flush/forward control for the five-stage pipeline.
//           Optional HAZARD_PERF_CNT_EN adds stall-cycle and flush counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  hazard_unit_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles_o
  , output logic [CNT_W-1:0] flush_count_o
`endif
);

  localparam logic [REG_ADDR_W-1:0] c_X0 = '0;

  hz_state_e  r_state;
  logic       w_mem_wait;
  logic       w_branch;
  logic       w_rd_match;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_mem_wait = bus.mem_req_M && !bus.dmem_ready;
  assign w_branch   = bus.branch_taken_E && !w_mem_wait;

  assign w_rd_match = (bus.use_rs1_D && (bus.rs1_D == bus.rd_E)) ||
                      (bus.use_rs2_D && (bus.rs2_D == bus.rd_E));

  // Load-use is masked for the one cycle after a bubble and by any higher-priority event
  assign w_load_use = (r_state != LOAD_BUBBLE) && !w_mem_wait && !bus.branch_taken_E &&
                      bus.is_load_E && bus.reg_we_E && (bus.rd_E != c_X0) && w_rd_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      if (w_mem_wait)
        r_state <= MEM_WAIT;
      else if (w_load_use)
        r_state <= LOAD_BUBBLE;
      else
        r_state <= RUN;
    end
  end

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs   (bus.rs1_E),
    .i_rd_M (bus.rd_M),
    .i_we_M (bus.reg_we_M),
    .i_rd_W (bus.rd_W),
    .i_we_W (bus.reg_we_W),
    .o_sel  (w_fwd_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs   (bus.rs2_E),
    .i_rd_M (bus.rd_M),
    .i_we_M (bus.reg_we_M),
    .i_rd_W (bus.rd_W),
    .i_we_W (bus.reg_we_W),
    .o_sel  (w_fwd_b)
  );

  // Every control output is forced low while reset is held
  assign bus.stall_F = rst_n & (w_mem_wait | w_load_use);
  assign bus.stall_D = rst_n & (w_mem_wait | w_load_use);
  assign bus.stall_E = rst_n & w_mem_wait;
  assign bus.stall_M = rst_n & w_mem_wait;
  assign bus.flush_W = rst_n & w_mem_wait;
  assign bus.flush_D = rst_n & w_branch;
  assign bus.flush_E = rst_n & (w_branch | w_load_use);
  assign bus.fwd_A_E = rst_n ? w_fwd_a : FWD_RF;
  assign bus.fwd_B_E = rst_n ? w_fwd_b : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_mem_wait || w_load_use)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign flush_count_o  = r_flush_cnt;
`endif

endmodule

`default_nettype wire
